// File: rtl/ysyx_22040895_lsu_if.sv
// Load/store unit bus interface.
// Bundles the execute-side request/response handshake and the 64-bit
// valid/ready memory bus into one interface.
//   master : the LSU view. It takes requests from execute, returns results,
//            and drives the memory request channel.
//   slave  : the environment view (execute stage plus memory).
// Signals:
//   req_valid_i_lsu/req_ready_o_lsu, sl_i_lsu, munit_i_lsu, addr_i_lsu, wdata_i_lsu
//   done_o_lsu, rdata_o_lsu, err_o_lsu
//   mem_req_valid_o_lsu/mem_req_ready_i_lsu, mem_addr_o_lsu, mem_we_o_lsu,
//   mem_wdata_o_lsu, mem_wmask_o_lsu, mem_rsp_valid_i_lsu, mem_rdata_i_lsu
interface ysyx_22040895_lsu_if #(
  parameter int XLEN = 64
);
  logic            req_valid_i_lsu;
  logic            req_ready_o_lsu;
  logic [1:0]      sl_i_lsu;
  logic [1:0]      munit_i_lsu;
  logic [XLEN-1:0] addr_i_lsu;
  logic [XLEN-1:0] wdata_i_lsu;
  logic            done_o_lsu;
  logic [XLEN-1:0] rdata_o_lsu;
  logic            err_o_lsu;
  logic            mem_req_valid_o_lsu;
  logic            mem_req_ready_i_lsu;
  logic [XLEN-1:0] mem_addr_o_lsu;
  logic            mem_we_o_lsu;
  logic [XLEN-1:0] mem_wdata_o_lsu;
  logic [7:0]      mem_wmask_o_lsu;
  logic            mem_rsp_valid_i_lsu;
  logic [XLEN-1:0] mem_rdata_i_lsu;

  modport master (
    input  req_valid_i_lsu, sl_i_lsu, munit_i_lsu, addr_i_lsu, wdata_i_lsu,
           mem_req_ready_i_lsu, mem_rsp_valid_i_lsu, mem_rdata_i_lsu,
    output req_ready_o_lsu, done_o_lsu, rdata_o_lsu, err_o_lsu,
           mem_req_valid_o_lsu, mem_addr_o_lsu, mem_we_o_lsu,
           mem_wdata_o_lsu, mem_wmask_o_lsu
  );

  modport slave (
    output req_valid_i_lsu, sl_i_lsu, munit_i_lsu, addr_i_lsu, wdata_i_lsu,
           mem_req_ready_i_lsu, mem_rsp_valid_i_lsu, mem_rdata_i_lsu,
    input  req_ready_o_lsu, done_o_lsu, rdata_o_lsu, err_o_lsu,
           mem_req_valid_o_lsu, mem_addr_o_lsu, mem_we_o_lsu,
           mem_wdata_o_lsu, mem_wmask_o_lsu
  );
endinterface

// File: rtl/ysyx_22040895_lsu.sv
// Multi-cycle load/store unit.
// Latches one request from execute, issues it on a 64-bit valid/ready memory
// bus with byte-lane write masks, then extends the load data and returns it
// with a one-cycle done pulse. Misaligned accesses and sl=00 complete at once
// without any bus activity. A missing response raises err after RSP_TIMEOUT
// cycles in RESP.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : ysyx_22040895_lsu_if.master (request, result and memory bus)
module ysyx_22040895_lsu #(
  parameter int XLEN        = 64,
  parameter int RSP_TIMEOUT = 255
) (
  input logic                 clk,
  input logic                 rst,
  ysyx_22040895_lsu_if.master bus
);
  localparam int CW = $clog2(RSP_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sl_q, munit_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
  logic            err_q;
  logic [CW-1:0]   cnt_q, cnt_inc;

  logic            misal_in, accept, rsp_hit, tmo_hit;
  logic [XLEN-1:0] ld_sh, ld_ext, st_data;
  logic [7:0]      st_base, st_mask;
  logic            sx, is_store, is_load;

  assign is_store = (sl_q == 2'b01);
  assign is_load  = sl_q[1];
  assign cnt_inc  = cnt_q + CW'(1);

  // Alignment is judged on the incoming request so the decision is made on
  // the accept edge.
  always_comb begin
    misal_in = 1'b0;
    case (bus.munit_i_lsu)
      2'b01:   misal_in = bus.addr_i_lsu[0];
      2'b10:   misal_in = |bus.addr_i_lsu[1:0];
      2'b11:   misal_in = |bus.addr_i_lsu[2:0];
      default: misal_in = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    rsp_hit = 1'b0;
    tmo_hit = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid_i_lsu) begin
        accept  = 1'b1;
        state_d = (bus.sl_i_lsu == 2'b00 || misal_in) ? DONE : REQ;
      end
      REQ:  if (bus.mem_req_ready_i_lsu) state_d = RESP;
      RESP: if (bus.mem_rsp_valid_i_lsu) begin
        rsp_hit = 1'b1;
        state_d = DONE;
      end else if (cnt_inc == CW'(RSP_TIMEOUT)) begin
        tmo_hit = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load extraction: shift the addressed field down to bit 0, then extend.
  // sl=10 sign-extends and sl=11 zero-extends.
  always_comb begin
    ld_sh = bus.mem_rdata_i_lsu >> {addr_q[2:0], 3'b000};
    sx    = ~sl_q[0];
    case (munit_q)
      2'b00:   ld_ext = {{(XLEN-8){sx & ld_sh[7]}},   ld_sh[7:0]};
      2'b01:   ld_ext = {{(XLEN-16){sx & ld_sh[15]}}, ld_sh[15:0]};
      2'b10:   ld_ext = {{(XLEN-32){sx & ld_sh[31]}}, ld_sh[31:0]};
      default: ld_ext = ld_sh;
    endcase
  end

  // Store lane placement.
  always_comb begin
    case (munit_q)
      2'b00:   st_base = 8'h01;
      2'b01:   st_base = 8'h03;
      2'b10:   st_base = 8'h0F;
      default: st_base = 8'hFF;
    endcase
    st_mask = st_base << addr_q[2:0];
    st_data = wdata_q << {addr_q[2:0], 3'b000};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sl_q    <= '0;
      munit_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sl_q    <= bus.sl_i_lsu;
        munit_q <= bus.munit_i_lsu;
        addr_q  <= bus.addr_i_lsu;
        wdata_q <= bus.wdata_i_lsu;
        rdata_q <= '0;
        // sl=00 performs no access, so it cannot be misaligned.
        err_q   <= misal_in && (bus.sl_i_lsu != 2'b00);
      end
      case (state_q)
        REQ:  if (bus.mem_req_ready_i_lsu) cnt_q <= '0;
        RESP: begin
          cnt_q <= cnt_inc;
          if (rsp_hit && is_load) rdata_q <= ld_ext;
          if (tmo_hit)            err_q   <= 1'b1;
        end
        // Result registers are only non-zero while DONE is asserted.
        DONE: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Bus outputs are zero outside REQ so idle bus values are deterministic.
  assign bus.req_ready_o_lsu     = (state_q == IDLE);
  assign bus.done_o_lsu          = (state_q == DONE);
  assign bus.rdata_o_lsu         = rdata_q;
  assign bus.err_o_lsu           = err_q;
  assign bus.mem_req_valid_o_lsu = (state_q == REQ);
  assign bus.mem_addr_o_lsu      = (state_q == REQ) ? {addr_q[XLEN-1:3], 3'b000} : '0;
  assign bus.mem_we_o_lsu        = (state_q == REQ) && is_store;
  assign bus.mem_wdata_o_lsu     = (state_q == REQ) ? st_data : '0;
  assign bus.mem_wmask_o_lsu     = (state_q == REQ && is_store) ? st_mask : 8'h00;
endmodule

// File: tb/tb_ysyx_22040895_lsu.sv
// Directed, table-driven bench for ysyx_22040895_lsu (RSP_TIMEOUT=4).
module tb_ysyx_22040895_lsu;
  logic clk, rst;
  ysyx_22040895_lsu_if #(.XLEN(64)) bus();

  ysyx_22040895_lsu #(.XLEN(64), .RSP_TIMEOUT(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  sl, munit;
    logic [63:0] addr, wdata, mrdata;
    int          rdy_dly, rsp_dly;  // rsp_dly < 0: memory never responds
    bit          e_bus;
    logic [63:0] e_addr;
    logic        e_we;
    logic [7:0]  e_wmask;
    logic [63:0] e_wdata, e_rdata;
    logic        e_err;
    int          e_lat;
  } vec_t;

  vec_t tv[$];
  int n_vec = 0, n_chk = 0, n_err = 0;

  function automatic vec_t mk(string n, logic [1:0] sl, logic [1:0] mu,
      logic [63:0] addr, logic [63:0] wdata, logic [63:0] mrdata, int rdy,
      int rsp, bit e_bus, logic [63:0] e_addr, logic e_we, logic [7:0] e_wmask,
      logic [63:0] e_wdata, logic [63:0] e_rdata, logic e_err, int e_lat);
    vec_t v;
    v.name = n; v.sl = sl; v.munit = mu; v.addr = addr; v.wdata = wdata;
    v.mrdata = mrdata; v.rdy_dly = rdy; v.rsp_dly = rsp; v.e_bus = e_bus;
    v.e_addr = e_addr; v.e_we = e_we; v.e_wmask = e_wmask;
    v.e_wdata = e_wdata; v.e_rdata = e_rdata; v.e_err = e_err; v.e_lat = e_lat;
    return v;
  endfunction

  function automatic logic [63:0] lanes(logic [7:0] m);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = {8{m[i]}};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] sl, input logic [1:0] mu,
                           input logic [63:0] addr, input logic [63:0] wdata);
    bus.req_valid_i_lsu = 1'b1;
    bus.sl_i_lsu = sl; bus.munit_i_lsu = mu;
    bus.addr_i_lsu = addr; bus.wdata_i_lsu = wdata;
  endtask

  // Applies one request and plays the memory side with the given delays.
  task automatic run(input vec_t v);
    int cyc, hold, rcnt, phase;
    bit seen;
    logic [63:0] a0;
    n_vec++;
    hold = 0; rcnt = 0; phase = 0; seen = 0; a0 = '0;
    bus.mem_rdata_i_lsu = v.mrdata;
    drive_req(v.sl, v.munit, v.addr, v.wdata);
    step();
    bus.req_valid_i_lsu = 1'b0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      bus.mem_req_ready_i_lsu = 1'b0;
      bus.mem_rsp_valid_i_lsu = 1'b0;
      if (bus.done_o_lsu) break;
      if (phase == 0 && bus.mem_req_valid_o_lsu) begin
        if (!seen) begin
          seen = 1; a0 = bus.mem_addr_o_lsu;
          chk({v.name, " mem_addr"}, bus.mem_addr_o_lsu, v.e_addr);
          chk({v.name, " mem_we"}, 64'(bus.mem_we_o_lsu), 64'(v.e_we));
          chk({v.name, " wmask"}, 64'(bus.mem_wmask_o_lsu), 64'(v.e_wmask));
          if (v.e_we)
            chk({v.name, " wdata"}, bus.mem_wdata_o_lsu & lanes(v.e_wmask), v.e_wdata);
        end else begin
          chk({v.name, " addr_stable"}, bus.mem_addr_o_lsu, a0);
        end
        if (hold == v.rdy_dly) begin
          bus.mem_req_ready_i_lsu = 1'b1;
          phase = 1;
        end else hold++;
      end else if (phase == 1) begin
        if (v.rsp_dly >= 0 && rcnt == v.rsp_dly) bus.mem_rsp_valid_i_lsu = 1'b1;
        rcnt++;
      end
      step();
    end
    chk({v.name, " done_seen"}, 64'(bus.done_o_lsu), 64'd1);
    chk({v.name, " latency"}, 64'(cyc), 64'(v.e_lat));
    chk({v.name, " err"}, 64'(bus.err_o_lsu), 64'(v.e_err));
    chk({v.name, " rdata"}, bus.rdata_o_lsu, v.e_rdata);
    chk({v.name, " bus_used"}, 64'(seen), 64'(v.e_bus));
    chk({v.name, " ready_in_done"}, 64'(bus.req_ready_o_lsu), 64'd0);
    step();
    chk({v.name, " done_one_cycle"}, 64'(bus.done_o_lsu), 64'd0);
    chk({v.name, " ready_after"}, 64'(bus.req_ready_o_lsu), 64'd1);
  endtask

  initial begin
    bus.req_valid_i_lsu = 0; bus.sl_i_lsu = 0; bus.munit_i_lsu = 0;
    bus.addr_i_lsu = 0; bus.wdata_i_lsu = 0; bus.mem_req_ready_i_lsu = 0;
    bus.mem_rsp_valid_i_lsu = 0; bus.mem_rdata_i_lsu = 0;
    rst = 1'b1;

    //           name   sl     mu     addr                   wdata                  mrdata                 rdy rsp bus e_addr         we wmask  e_wdata                e_rdata                err lat
    tv.push_back(mk("lb",  2'b10, 2'b00, 64'h80000003, 64'h0, 64'h00000000_80FF0000, 0, 0, 1, 64'h80000000, 0, 8'h00, 64'h0, 64'hFFFFFFFF_FFFFFF80, 0, 3));
    tv.push_back(mk("lbu", 2'b11, 2'b00, 64'h80000003, 64'h0, 64'h00000000_80FF0000, 0, 0, 1, 64'h80000000, 0, 8'h00, 64'h0, 64'h00000000_00000080, 0, 3));
    tv.push_back(mk("lh",  2'b10, 2'b01, 64'h2002, 64'h0, 64'h00000000_80010000, 0, 0, 1, 64'h2000, 0, 8'h00, 64'h0, 64'hFFFFFFFF_FFFF8001, 0, 3));
    tv.push_back(mk("lhu", 2'b11, 2'b01, 64'h2006, 64'h0, 64'hBEEF0000_00000000, 0, 0, 1, 64'h2000, 0, 8'h00, 64'h0, 64'h00000000_0000BEEF, 0, 3));
    tv.push_back(mk("lw",  2'b10, 2'b10, 64'h2004, 64'h0, 64'h89ABCDEF_00000000, 0, 0, 1, 64'h2000, 0, 8'h00, 64'h0, 64'hFFFFFFFF_89ABCDEF, 0, 3));
    tv.push_back(mk("lwu", 2'b11, 2'b10, 64'h2004, 64'h0, 64'h89ABCDEF_00000000, 0, 0, 1, 64'h2000, 0, 8'h00, 64'h0, 64'h00000000_89ABCDEF, 0, 3));
    tv.push_back(mk("ld",  2'b10, 2'b11, 64'h3000, 64'h0, 64'hDEADBEEF_CAFEF00D, 0, 2, 1, 64'h3000, 0, 8'h00, 64'h0, 64'hDEADBEEF_CAFEF00D, 0, 5));
    tv.push_back(mk("sb",  2'b01, 2'b00, 64'h1005, 64'hFFFFFFFF_FFFFFFAB, 64'h55555555_55555555, 0, 0, 1, 64'h1000, 1, 8'h20, 64'h0000AB00_00000000, 64'h0, 0, 3));
    tv.push_back(mk("sh",  2'b01, 2'b01, 64'h1006, 64'h1234, 64'h55555555_55555555, 0, 0, 1, 64'h1000, 1, 8'hC0, 64'h12340000_00000000, 64'h0, 0, 3));
    tv.push_back(mk("sw",  2'b01, 2'b10, 64'h1004, 64'hCAFEBABE, 64'h0, 0, 0, 1, 64'h1000, 1, 8'hF0, 64'hCAFEBABE_00000000, 64'h0, 0, 3));
    tv.push_back(mk("sd",  2'b01, 2'b11, 64'h1000, 64'h01234567_89ABCDEF, 64'h0, 0, 1, 1, 64'h1000, 1, 8'hFF, 64'h01234567_89ABCDEF, 64'h0, 0, 4));
    tv.push_back(mk("lw_mis", 2'b10, 2'b10, 64'h1002, 64'h0, 64'h0, 0, 0, 0, 64'h0, 0, 8'h00, 64'h0, 64'h0, 1, 1));
    tv.push_back(mk("lh_mis", 2'b11, 2'b01, 64'h1001, 64'h0, 64'h0, 0, 0, 0, 64'h0, 0, 8'h00, 64'h0, 64'h0, 1, 1));
    tv.push_back(mk("sd_mis", 2'b01, 2'b11, 64'h1004, 64'h0, 64'h0, 0, 0, 0, 64'h0, 0, 8'h00, 64'h0, 64'h0, 1, 1));
    tv.push_back(mk("none",   2'b00, 2'b10, 64'h1000, 64'h0, 64'h0, 0, 0, 0, 64'h0, 0, 8'h00, 64'h0, 64'h0, 0, 1));
    tv.push_back(mk("lb_bp",  2'b10, 2'b00, 64'h80000003, 64'h0, 64'h00000000_80FF0000, 5, 0, 1, 64'h80000000, 0, 8'h00, 64'h0, 64'hFFFFFFFF_FFFFFF80, 0, 8));
    tv.push_back(mk("lw_tmo", 2'b10, 2'b10, 64'h2000, 64'h0, 64'hFFFFFFFF_80000000, 0, -1, 1, 64'h2000, 0, 8'h00, 64'h0, 64'h0, 1, 6));

    step(); step();
    rst = 1'b0;

    // Reset state
    n_vec++;
    chk("rst req_ready", 64'(bus.req_ready_o_lsu), 64'd1);
    chk("rst done", 64'(bus.done_o_lsu), 64'd0);
    chk("rst err", 64'(bus.err_o_lsu), 64'd0);
    chk("rst mem_req_valid", 64'(bus.mem_req_valid_o_lsu), 64'd0);
    chk("rst mem_we", 64'(bus.mem_we_o_lsu), 64'd0);
    chk("rst wmask", 64'(bus.mem_wmask_o_lsu), 64'd0);
    chk("rst rdata", bus.rdata_o_lsu, 64'd0);
    chk("rst mem_addr", bus.mem_addr_o_lsu, 64'd0);
    chk("rst mem_wdata", bus.mem_wdata_o_lsu, 64'd0);

    foreach (tv[i]) run(tv[i]);

    // Reset while waiting in RESP, then a late response that must be ignored.
    n_vec++;
    drive_req(2'b10, 2'b10, 64'h2000, 64'h0);
    step();
    bus.req_valid_i_lsu = 1'b0;
    chk("mid mem_req_valid", 64'(bus.mem_req_valid_o_lsu), 64'd1);
    bus.mem_req_ready_i_lsu = 1'b1;
    step();
    bus.mem_req_ready_i_lsu = 1'b0;
    chk("mid in_resp", 64'({bus.mem_req_valid_o_lsu, bus.req_ready_o_lsu, bus.done_o_lsu}), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid rst req_ready", 64'(bus.req_ready_o_lsu), 64'd1);
    chk("mid rst done", 64'(bus.done_o_lsu), 64'd0);
    bus.mem_rsp_valid_i_lsu = 1'b1;
    bus.mem_rdata_i_lsu = 64'h11111111_11111111;
    step();
    bus.mem_rsp_valid_i_lsu = 1'b0;
    chk("late rsp done", 64'(bus.done_o_lsu), 64'd0);
    chk("late rsp req_ready", 64'(bus.req_ready_o_lsu), 64'd1);
    run(mk("lw_after_rst", 2'b10, 2'b10, 64'h2000, 64'h0, 64'hFFFFFFFF_80000000, 0, 0, 1,
           64'h2000, 0, 8'h00, 64'h0, 64'hFFFFFFFF_80000000, 0, 3));

    // Back-to-back with req_valid held: ld, then a misaligned lw.
    n_vec++;
    bus.mem_rdata_i_lsu = 64'hDEADBEEF_CAFEF00D;
    drive_req(2'b10, 2'b11, 64'h3000, 64'h0);
    step();
    chk("b2b req_valid", 64'(bus.mem_req_valid_o_lsu), 64'd1);
    bus.mem_req_ready_i_lsu = 1'b1;
    step();
    bus.mem_req_ready_i_lsu = 1'b0;
    bus.mem_rsp_valid_i_lsu = 1'b1;
    step();
    bus.mem_rsp_valid_i_lsu = 1'b0;
    chk("b2b done1", 64'(bus.done_o_lsu), 64'd1);
    chk("b2b rdata1", bus.rdata_o_lsu, 64'hDEADBEEF_CAFEF00D);
    chk("b2b ready_in_done", 64'(bus.req_ready_o_lsu), 64'd0);
    drive_req(2'b10, 2'b10, 64'h1002, 64'h0);
    step();
    chk("b2b idle ready", 64'(bus.req_ready_o_lsu), 64'd1);
    chk("b2b idle done", 64'(bus.done_o_lsu), 64'd0);
    step();
    bus.req_valid_i_lsu = 1'b0;
    chk("b2b done2", 64'(bus.done_o_lsu), 64'd1);
    chk("b2b err2", 64'(bus.err_o_lsu), 64'd1);
    chk("b2b no_bus2", 64'(bus.mem_req_valid_o_lsu), 64'd0);
    step();
    chk("b2b done2_once", 64'(bus.done_o_lsu), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
